// File: rtl/ravenoc_pkt_injector_pkg.sv
// Shared NoC types for the packet injector slice: mesh geometry, flit layout
// and the injector FSM state encoding.
package ravenoc_pkt_injector_pkg;

  localparam int unsigned NOC_CFG_SZ_ROWS = 3;
  localparam int unsigned NOC_CFG_SZ_COLS = 3;
  localparam int unsigned NOC_CFG_MAX_VC  = 3;
  localparam int unsigned XWidth          = $clog2(NOC_CFG_SZ_ROWS);
  localparam int unsigned YWidth          = $clog2(NOC_CFG_SZ_COLS);
  localparam int unsigned VcWidth         = $clog2(NOC_CFG_MAX_VC);
  localparam int unsigned PktWidth        = 8;
  localparam int unsigned FlitDataWidth   = 32;
  localparam int unsigned MinDataWidth    = FlitDataWidth - 2*(XWidth+YWidth) - PktWidth;

  typedef enum logic [1:0] {
    HEAD_FLIT = 2'd0,
    BODY_FLIT = 2'd1,
    TAIL_FLIT = 2'd2
  } flit_type_t;

  typedef struct packed {
    logic [XWidth-1:0]       x_dest;
    logic [YWidth-1:0]       y_dest;
    logic [XWidth-1:0]       x_src;
    logic [YWidth-1:0]       y_src;
    logic [PktWidth-1:0]     pkt_width;
    logic [MinDataWidth-1:0] data;
  } s_flit_head_data_t;

  typedef struct packed {
    flit_type_t               ftype;
    logic [FlitDataWidth-1:0] data;
  } s_flit_t;

  typedef struct packed {
    s_flit_t              fdata;
    logic [VcWidth-1:0]   vc_id;
    logic                 valid;
  } s_flit_req_t;

  typedef struct packed {
    logic [NOC_CFG_MAX_VC-1:0] ready;
  } s_flit_resp_t;

  typedef enum logic [1:0] {
    INJ_IDLE,
    INJ_HEAD,
    INJ_BODY
  } inj_st_t;

  function automatic logic cmd_legal(input logic [XWidth-1:0]  x,
                                     input logic [YWidth-1:0]  y,
                                     input logic [VcWidth-1:0] vc);
    return (32'(x) < NOC_CFG_SZ_ROWS) && (32'(y) < NOC_CFG_SZ_COLS) &&
           (32'(vc) < NOC_CFG_MAX_VC);
  endfunction

endpackage

// File: rtl/ravenoc_pkt_injector_if.sv
// Router port flit channel: request (flit, vc, valid) one way, per-VC ready back.
interface router_if;
  import ravenoc_pkt_injector_pkg::*;

  s_flit_req_t  req;
  s_flit_resp_t resp;

  modport master    (output req, input resp);
  modport slave     (input req, output resp);
  modport send_flit (output req, input resp);
  modport recv_flit (input req, output resp);
endinterface

// File: rtl/ravenoc_flit_oreg.sv
// Single-entry flit output register; contents held stable while stalled.
module ravenoc_flit_oreg
  import ravenoc_pkt_injector_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      arst_i,
  input  logic                      ld_i,
  input  s_flit_t                   flit_i,
  input  logic [VcWidth-1:0]        vc_i,
  input  logic [NOC_CFG_MAX_VC-1:0] ready_i,
  output s_flit_req_t               req_o,
  output logic                      ld_ok_o,
  output logic                      acc_o
);

  s_flit_t            flit_q;
  logic [VcWidth-1:0] vc_q;
  logic               valid_q;

  assign acc_o   = valid_q && ready_i[vc_q];
  assign ld_ok_o = !valid_q || acc_o;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      flit_q  <= '0;
      vc_q    <= '0;
      valid_q <= 1'b0;
    end else if (ld_ok_o) begin
      valid_q <= ld_i;
      if (ld_i) begin
        flit_q <= flit_i;
        vc_q   <= vc_i;
      end
    end
  end

  assign req_o.fdata = flit_q;
  assign req_o.vc_id = vc_q;
  assign req_o.valid = valid_q;

endmodule

// File: rtl/ravenoc_pkt_injector.sv
// Packet injector: turns a command plus payload stream into HEAD/BODY/TAIL
// flits on one router port, with per-VC valid/ready handshake.
module ravenoc_pkt_injector
  import ravenoc_pkt_injector_pkg::*;
#(
  parameter int unsigned ROUTER_X_ID = 0,
  parameter int unsigned ROUTER_Y_ID = 0,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                     clk_noc,
  input  logic                     arst_noc,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [XWidth-1:0]        cmd_x_dest,
  input  logic [YWidth-1:0]        cmd_y_dest,
  input  logic [VcWidth-1:0]       cmd_vc,
  input  logic [PktWidth-1:0]      cmd_len,
  input  logic [MinDataWidth-1:0]  cmd_hdr_data,
  input  logic                     data_valid,
  output logic                     data_ready,
  input  logic [FlitDataWidth-1:0] data,
  router_if.send_flit              send,
  output logic                     busy,
  output logic                     err_dest,
  output logic [CNT_WIDTH-1:0]     pkt_cnt,
  output logic [CNT_WIDTH-1:0]     flit_cnt
);

  inj_st_t             st_q, st_d;
  logic [VcWidth-1:0]  vc_q, vc_d;
  logic [PktWidth-1:0] rem_q, rem_d;
  logic                err_q, err_d;
  logic                rdy_en_q;
  logic [CNT_WIDTH-1:0] pkt_cnt_q, flit_cnt_q;

  logic               ld_en, ld_ok, acc, legal, pkt_done;
  s_flit_t            ld_flit;
  logic [VcWidth-1:0] ld_vc;
  s_flit_req_t        req;
  s_flit_head_data_t  head, sent_hd;

  ravenoc_flit_oreg u_oreg (
    .clk_i   (clk_noc),
    .arst_i  (arst_noc),
    .ld_i    (ld_en),
    .flit_i  (ld_flit),
    .vc_i    (ld_vc),
    .ready_i (send.resp.ready),
    .req_o   (req),
    .ld_ok_o (ld_ok),
    .acc_o   (acc)
  );

  assign send.req = req;
  assign legal    = cmd_legal(cmd_x_dest, cmd_y_dest, cmd_vc);

  always_comb begin
    head           = '0;
    head.x_dest    = cmd_x_dest;
    head.y_dest    = cmd_y_dest;
    head.x_src     = XWidth'(ROUTER_X_ID);
    head.y_src     = YWidth'(ROUTER_Y_ID);
    head.pkt_width = cmd_len;
    head.data      = cmd_hdr_data;
  end

  // Packet completes when the tail, or a head with zero length, leaves the register
  assign sent_hd  = req.fdata.data;
  assign pkt_done = acc && ((req.fdata.ftype == TAIL_FLIT) ||
                   ((req.fdata.ftype == HEAD_FLIT) && (sent_hd.pkt_width == '0)));

  always_ff @(posedge clk_noc or posedge arst_noc) begin
    if (arst_noc) begin
      st_q       <= INJ_IDLE;
      vc_q       <= '0;
      rem_q      <= '0;
      err_q      <= 1'b0;
      rdy_en_q   <= 1'b0;
      pkt_cnt_q  <= '0;
      flit_cnt_q <= '0;
    end else begin
      st_q     <= st_d;
      vc_q     <= vc_d;
      rem_q    <= rem_d;
      err_q    <= err_d;
      rdy_en_q <= 1'b1;
      if (acc)      flit_cnt_q <= flit_cnt_q + CNT_WIDTH'(1);
      if (pkt_done) pkt_cnt_q  <= pkt_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    st_d  = st_q;
    vc_d  = vc_q;
    rem_d = rem_q;
    err_d = 1'b0;
    unique case (st_q)
      INJ_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (!legal) begin
            err_d = 1'b1;
          end else begin
            vc_d  = cmd_vc;
            rem_d = cmd_len;
            if (cmd_len != '0) st_d = INJ_BODY;
          end
        end
      end
      INJ_BODY: begin
        if (data_valid && data_ready) begin
          rem_d = rem_q - PktWidth'(1);
          if (rem_q == PktWidth'(1)) st_d = INJ_IDLE;
        end
      end
      default: st_d = INJ_IDLE;
    endcase
  end

  // In IDLE the command is gated only by the output register, so a new head
  // can follow a tail that is accepted in the same cycle.
  always_comb begin
    cmd_ready  = 1'b0;
    data_ready = 1'b0;
    ld_en      = 1'b0;
    ld_flit    = '0;
    ld_vc      = vc_q;
    unique case (st_q)
      INJ_IDLE: begin
        cmd_ready     = rdy_en_q && ld_ok;
        ld_en         = cmd_valid && cmd_ready && legal;
        ld_vc         = cmd_vc;
        ld_flit.ftype = HEAD_FLIT;
        ld_flit.data  = head;
      end
      INJ_BODY: begin
        data_ready    = ld_ok;
        ld_en         = data_valid && ld_ok;
        ld_flit.ftype = (rem_q == PktWidth'(1)) ? TAIL_FLIT : BODY_FLIT;
        ld_flit.data  = data;
      end
      default: ;
    endcase
  end

  assign busy     = (st_q != INJ_IDLE) || req.valid;
  assign err_dest = err_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign flit_cnt = flit_cnt_q;

endmodule

// File: tb/tb_ravenoc_pkt_injector.sv
// Scoreboard bench for ravenoc_pkt_injector: directed packets, stalls, errors, reset.
module tb_ravenoc_pkt_injector;
  import ravenoc_pkt_injector_pkg::*;

  localparam logic [1:0] T_HEAD = 2'd0;
  localparam logic [1:0] T_BODY = 2'd1;
  localparam logic [1:0] T_TAIL = 2'd2;

  typedef struct packed {
    logic [33:0] f;
    logic [1:0]  vc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [1:0]  cmd_x = '0, cmd_y = '0, cmd_vc = '0;
  logic [7:0]  cmd_len = '0;
  logic [15:0] cmd_hdr = '0;
  logic        data_valid = 1'b0, data_ready;
  logic [31:0] data = '0;
  logic        busy, err_dest;
  logic [15:0] pkt_cnt, flit_cnt;

  exp_t exp_q[$];
  int   acc_cyc[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  router_if rif ();

  ravenoc_pkt_injector #(.ROUTER_X_ID(2), .ROUTER_Y_ID(1), .CNT_WIDTH(16)) dut (
    .clk_noc      (clk),
    .arst_noc     (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_x_dest   (cmd_x),
    .cmd_y_dest   (cmd_y),
    .cmd_vc       (cmd_vc),
    .cmd_len      (cmd_len),
    .cmd_hdr_data (cmd_hdr),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .data         (data),
    .send         (rif),
    .busy         (busy),
    .err_dest     (err_dest),
    .pkt_cnt      (pkt_cnt),
    .flit_cnt     (flit_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Source fields are the DUT parameters ROUTER_X_ID=2, ROUTER_Y_ID=1
  function automatic logic [33:0] mk_head(input logic [1:0] x, input logic [1:0] y,
                                          input logic [7:0] len, input logic [15:0] hdr);
    return {T_HEAD, x, y, 2'd2, 2'd1, len, hdr};
  endfunction

  // Monitor: every accepted flit is popped from the scoreboard and compared
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rif.req.valid && rif.resp.ready[rif.req.vc_id]) begin
        acc_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_flit actual=%0h required=none", rif.req.fdata);
        end else begin
          e = exp_q.pop_front();
          chk("flit_fdata", 64'(rif.req.fdata), 64'(e.f));
          chk("flit_vc", 64'(rif.req.vc_id), 64'(e.vc));
        end
      end
    end
  end

  task automatic issue_cmd(input logic [1:0] x, input logic [1:0] y, input logic [1:0] vc,
                           input logic [7:0] len, input logic [15:0] hdr);
    int n;
    n = 0;
    cmd_x = x; cmd_y = y; cmd_vc = vc; cmd_len = len; cmd_hdr = hdr;
    cmd_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 50);
    if (!cmd_ready) chk("cmd_accept_timeout", 64'(cmd_ready), 64'd1);
    else if (x < 2'd3 && y < 2'd3 && vc < 2'd3) exp_q.push_back({mk_head(x, y, len, hdr), vc});
    @(posedge clk); #1;
  endtask

  task automatic stream(input logic [31:0] w, input logic [1:0] t, input logic [1:0] vc);
    int n;
    n = 0;
    data = w;
    data_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!data_ready && n < 50);
    if (!data_ready) chk("data_accept_timeout", 64'(data_ready), 64'd1);
    else exp_q.push_back({t, w, vc});
    @(posedge clk); #1;
    data_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_idle", 64'(busy || exp_q.size() != 0), 64'd0);
  endtask

  task automatic chk_b2b(input string name, input int n);
    chk({name, "_count"}, 64'(acc_cyc.size()), 64'(n));
    for (int i = 1; i < acc_cyc.size(); i++)
      chk({name, "_gap"}, 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [33:0] sf;
    logic [1:0]  sv;
    int          n;
    rif.resp.ready = '1;

    // Reset state
    #1;
    chk("rst_valid", 64'(rif.req.valid), 64'd0);
    chk("rst_fdata", 64'(rif.req.fdata), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_data_ready", 64'(data_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err_dest), 64'd0);
    chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("rst_flit_cnt", 64'(flit_cnt), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

    // Four-flit packet, streamed back-to-back
    acc_cyc.delete();
    issue_cmd(2'd1, 2'd1, 2'd0, 8'd3, 16'h1234);
    cmd_valid = 1'b0;
    stream(32'hA, T_BODY, 2'd0);
    stream(32'hB, T_BODY, 2'd0);
    stream(32'hC, T_TAIL, 2'd0);
    drain();
    chk_b2b("pkt4", 4);
    chk("pkt4_pkt_cnt", 64'(pkt_cnt), 64'd1);
    chk("pkt4_flit_cnt", 64'(flit_cnt), 64'd4);

    // Same packet with a 5-cycle stall on the second flit
    fork
      begin
        issue_cmd(2'd0, 2'd2, 2'd0, 8'd3, 16'h0BEE);
        cmd_valid = 1'b0;
        stream(32'h11, T_BODY, 2'd0);
        stream(32'h22, T_BODY, 2'd0);
        stream(32'h33, T_TAIL, 2'd0);
      end
      begin
        n = 0;
        do begin
          @(posedge clk); #1;
          n++;
        end while (!(rif.req.valid && rif.req.fdata[33:32] == T_BODY) && n < 50);
        if (!(rif.req.valid && rif.req.fdata[33:32] == T_BODY)) begin
          chk("stall_body_timeout", 64'd0, 64'd1);
        end else begin
          rif.resp.ready[0] = 1'b0;
          sf = rif.req.fdata;
          sv = rif.req.vc_id;
          chk("stall_target", 64'(sf), 64'({T_BODY, 32'h11}));
          repeat (5) begin
            @(negedge clk);
            chk("stall_fdata", 64'(rif.req.fdata), 64'(sf));
            chk("stall_vc", 64'(rif.req.vc_id), 64'(sv));
            chk("stall_valid", 64'(rif.req.valid), 64'd1);
            chk("stall_data_ready", 64'(data_ready), 64'd0);
          end
          @(posedge clk); #1;
          rif.resp.ready[0] = 1'b1;
        end
      end
    join
    drain();
    chk("stall_pkt_cnt", 64'(pkt_cnt), 64'd2);
    chk("stall_flit_cnt", 64'(flit_cnt), 64'd8);

    // Two head-only packets back-to-back; first targets the own router
    acc_cyc.delete();
    issue_cmd(2'd2, 2'd1, 2'd1, 8'd0, 16'hAAAA);
    issue_cmd(2'd0, 2'd0, 2'd2, 8'd0, 16'h5555);
    cmd_valid = 1'b0;
    drain();
    chk_b2b("head_only", 2);
    chk("head_only_pkt_cnt", 64'(pkt_cnt), 64'd4);
    chk("head_only_flit_cnt", 64'(flit_cnt), 64'd10);

    // Illegal destination and illegal VC are dropped with a one-cycle error
    issue_cmd(2'd3, 2'd0, 2'd0, 8'd2, 16'hDEAD);
    cmd_valid = 1'b0;
    chk("bad_x_err", 64'(err_dest), 64'd1);
    chk("bad_x_valid", 64'(rif.req.valid), 64'd0);
    @(posedge clk); #1;
    chk("bad_x_err_clear", 64'(err_dest), 64'd0);
    chk("bad_x_busy", 64'(busy), 64'd0);
    issue_cmd(2'd1, 2'd0, 2'd3, 8'd0, 16'hBEEF);
    cmd_valid = 1'b0;
    chk("bad_vc_err", 64'(err_dest), 64'd1);
    @(posedge clk); #1;
    chk("bad_cnt_pkt", 64'(pkt_cnt), 64'd4);
    chk("bad_cnt_flit", 64'(flit_cnt), 64'd10);
    issue_cmd(2'd1, 2'd2, 2'd0, 8'd1, 16'h0042);
    cmd_valid = 1'b0;
    stream(32'h77, T_TAIL, 2'd0);
    drain();
    chk("after_bad_pkt_cnt", 64'(pkt_cnt), 64'd5);
    chk("after_bad_flit_cnt", 64'(flit_cnt), 64'd12);

    // Reset in the middle of a four-flit packet
    issue_cmd(2'd1, 2'd0, 2'd1, 8'd3, 16'hC0DE);
    cmd_valid = 1'b0;
    stream(32'h1, T_BODY, 2'd1);
    @(posedge clk); #1;
    chk("mid_flit_cnt", 64'(flit_cnt), 64'd14);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(rif.req.valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("mid_rst_flit_cnt", 64'(flit_cnt), 64'd0);
    chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("mid_rst_pending", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    issue_cmd(2'd2, 2'd2, 2'd1, 8'd1, 16'h0F0F);
    cmd_valid = 1'b0;
    stream(32'h99, T_TAIL, 2'd1);
    drain();
    chk("fresh_pkt_cnt", 64'(pkt_cnt), 64'd1);
    chk("fresh_flit_cnt", 64'(flit_cnt), 64'd2);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
